spmv_mem_arbiter: RTL and testbench

// - Shares the single PE memory port (ld/st, 48b addr, 64b d_or_tag, 3b response tag) among NUM_REQ stream fetchers.

---
 rtl/spmv_mem_arbiter_pkg.sv | 27 ++
 rtl/spmv_mem_arbiter_rr_arbiter.sv | 45 ++++
 rtl/spmv_mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_spmv_mem_arbiter.sv | 512 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spmv_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// spmv_mem_arbiter_pkg
// Shared widths and helpers for the PE memory port and its stream fetchers.
//   TAG_W   : response tag width (bounds the number of requesters to 8)
//   ADDR_W  : byte address width of the memory port
//   DATA_W  : store data / load response width
//   mem_op_e: kind of request selected by the arbiter in a given cycle
//   pack_tag: places a response tag in the low bits of the d_or_tag field
// ----------------------------------------------------------------------------
package spmv_mem_arbiter_pkg;

    localparam int TAG_W  = 3;
    localparam int ADDR_W = 48;
    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } mem_op_e;

    // On a load the data lane carries the tag so the response can be routed.
    function automatic logic [DATA_W-1:0] pack_tag(input logic [TAG_W-1:0] tag);
        return {{(DATA_W-TAG_W){1'b0}}, tag};
    endfunction

endpackage

// File: rtl/spmv_mem_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker.
//   req      in  N   request vector
//   ptr      in  PW  highest-priority index this cycle
//   grant    out N   one-hot grant (all zero when nothing requests)
//   next_ptr out PW  index after the winner, modulo N; equals ptr with no grant
// The search is split in two passes (indices at/after ptr, then below ptr)
// so every select uses a constant index and no modulo arithmetic is needed.
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] next_ptr
);

    logic found;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (PW'(i) >= ptr)) begin
                grant[i] = 1'b1;
                found    = 1'b1;
                next_ptr = (i == N-1) ? '0 : PW'(i + 1);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (PW'(i) < ptr)) begin
                grant[i] = 1'b1;
                found    = 1'b1;
                next_ptr = (i == N-1) ? '0 : PW'(i + 1);
            end
        end
    end

endmodule

// File: rtl/spmv_mem_arbiter.sv
// ----------------------------------------------------------------------------
// spmv_mem_arbiter
// Shares the single PE memory port among NUM_REQ stream fetchers with
// round-robin arbitration. Loads carry the requester index as tag and the
// response is routed back by that tag. Per-requester credits cap in-flight
// loads at the depth of each requester's response FIFO, so the arbiter never
// needs to stall the memory response path.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_ld/req_st     per-requester load/store request, held until granted
//   req_addr/req_d    per-requester address / store data, flattened vectors
//   req_grant         one-hot, same-cycle acceptance of a request
//   req_mem_ld/st     registered request strobes toward memory
//   req_mem_addr      registered address (holds when idle)
//   req_mem_d_or_tag  store data, or the packed tag on a load (holds when idle)
//   req_mem_stall     memory back-pressure: no grants while high
//   rsp_mem_push/tag/q load response from memory
//   rsp_mem_stall     always 0 (credits guarantee response space)
//   rsp_push/rsp_q    one-hot response strobe and broadcast data
//   outstanding_any   1 while any load is in flight
//   err_sticky        protocol error seen since reset
// ----------------------------------------------------------------------------
module spmv_mem_arbiter
    import spmv_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_OUTST = 16,
    parameter int CNT_W     = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_ld,
    input  logic [NUM_REQ-1:0]        req_st,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_d,
    output logic [NUM_REQ-1:0]        req_grant,
    output logic                      req_mem_ld,
    output logic                      req_mem_st,
    output logic [ADDR_W-1:0]         req_mem_addr,
    output logic [DATA_W-1:0]         req_mem_d_or_tag,
    input  logic                      req_mem_stall,
    input  logic                      rsp_mem_push,
    input  logic [TAG_W-1:0]          rsp_mem_tag,
    input  logic [DATA_W-1:0]         rsp_mem_q,
    output logic                      rsp_mem_stall,
    output logic [NUM_REQ-1:0]        rsp_push,
    output logic [DATA_W-1:0]         rsp_q,
    output logic                      outstanding_any,
    output logic                      err_sticky
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

    logic [CNT_W-1:0]   outst      [NUM_REQ];
    logic [CNT_W-1:0]   outst_next [NUM_REQ];
    logic [NUM_REQ-1:0] ld_st_clash;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] nonzero;
    logic [NUM_REQ-1:0] tag_hit;
    logic [NUM_REQ-1:0] cnt_inc;
    logic [NUM_REQ-1:0] cnt_dec;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      rr_next;
    mem_op_e            win_op;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_data;
    logic               rsp_valid;
    logic               rsp_err;
    logic               any_next;

    // ------------------------------------------------------------------
    // Eligibility: a requester asserting both ld and st is excluded and
    // flagged; loads additionally need a free credit.
    // ------------------------------------------------------------------
    always_comb begin
        ld_st_clash = '0;
        eligible    = '0;
        nonzero     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ld_st_clash[i] = req_ld[i] & req_st[i];
            nonzero[i]     = (outst[i] != '0);
            eligible[i]    = !req_mem_stall && !ld_st_clash[i] &&
                             (req_st[i] || (req_ld[i] && (outst[i] < CNT_MAX)));
        end
    end

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr (
        .req      (eligible),
        .ptr      (rr_ptr),
        .grant    (grant),
        .next_ptr (rr_next)
    );

    assign req_grant = grant;

    // Winner mux: grant is one-hot, so at most one branch fires.
    always_comb begin
        win_op   = OP_NONE;
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
                if (req_st[i]) begin
                    win_op   = OP_STORE;
                    win_data = req_d[i*DATA_W +: DATA_W];
                end else begin
                    win_op   = OP_LOAD;
                    win_data = pack_tag(TAG_W'(i));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response routing and credit bookkeeping. A tag that matches no
    // requester, or one with no load in flight, is dropped as an error.
    // ------------------------------------------------------------------
    always_comb begin
        tag_hit = '0;
        cnt_inc = '0;
        cnt_dec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            tag_hit[i] = rsp_mem_push && (rsp_mem_tag == TAG_W'(i));
            cnt_inc[i] = grant[i] && req_ld[i];
            cnt_dec[i] = tag_hit[i] && nonzero[i];
        end
        rsp_valid = |cnt_dec;
        rsp_err   = rsp_mem_push && !rsp_valid;
    end

    // A grant and a response for the same requester cancel out.
    always_comb begin
        any_next = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            outst_next[i] = outst[i];
            if (cnt_inc[i] && !cnt_dec[i] && (outst[i] < CNT_MAX))
                outst_next[i] = outst[i] + CNT_W'(1);
            else if (!cnt_inc[i] && cnt_dec[i] && (outst[i] != '0))
                outst_next[i] = outst[i] - CNT_W'(1);
            any_next = any_next | (outst_next[i] != '0);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr           <= '0;
            req_mem_ld       <= 1'b0;
            req_mem_st       <= 1'b0;
            req_mem_addr     <= '0;
            req_mem_d_or_tag <= '0;
            rsp_push         <= '0;
            rsp_q            <= '0;
            rsp_mem_stall    <= 1'b0;
            outstanding_any  <= 1'b0;
            err_sticky       <= 1'b0;
        end else begin
            if (|grant)
                rr_ptr <= rr_next;
            req_mem_ld <= (win_op == OP_LOAD);
            req_mem_st <= (win_op == OP_STORE);
            if (win_op != OP_NONE) begin
                req_mem_addr     <= win_addr;
                req_mem_d_or_tag <= win_data;
            end
            rsp_push <= cnt_dec;
            if (rsp_valid)
                rsp_q <= rsp_mem_q;
            rsp_mem_stall   <= 1'b0;
            outstanding_any <= any_next;
            err_sticky      <= err_sticky | rsp_err | (|ld_st_clash);
        end
    end

    // NOTE: the credit array is a handful of flops, not a RAM, so it is
    // cleared by reset like any other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++)
                outst[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                outst[i] <= outst_next[i];
        end
    end

endmodule

// File: tb/tb_spmv_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_spmv_mem_arbiter
// Scenario tasks drive the four requesters and the memory response port.
// Every cycle a reference model predicts the grant, pushes the expected
// memory request and response into queues, and pops/compares them when the
// DUT registers them one cycle later.
// ----------------------------------------------------------------------------
module tb_spmv_mem_arbiter;

    localparam int N = 4;
    localparam int MAXO = 16;

    typedef struct packed {
        logic        ld;
        logic        st;
        logic [47:0] addr;
        logic [63:0] dt;
    } iss_t;

    typedef struct packed {
        logic [2:0]  tag;
        logic [63:0] q;
    } rsp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_ld;
    logic [N-1:0]   req_st;
    logic [N*48-1:0] req_addr;
    logic [N*64-1:0] req_d;
    logic [N-1:0]   req_grant;
    logic           req_mem_ld;
    logic           req_mem_st;
    logic [47:0]    req_mem_addr;
    logic [63:0]    req_mem_d_or_tag;
    logic           req_mem_stall;
    logic           rsp_mem_push;
    logic [2:0]     rsp_mem_tag;
    logic [63:0]    rsp_mem_q;
    logic           rsp_mem_stall;
    logic [N-1:0]   rsp_push;
    logic [63:0]    rsp_q;
    logic           outstanding_any;
    logic           err_sticky;

    spmv_mem_arbiter #(
        .NUM_REQ   (N),
        .MAX_OUTST (MAXO),
        .CNT_W     (5)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_ld           (req_ld),
        .req_st           (req_st),
        .req_addr         (req_addr),
        .req_d            (req_d),
        .req_grant        (req_grant),
        .req_mem_ld       (req_mem_ld),
        .req_mem_st       (req_mem_st),
        .req_mem_addr     (req_mem_addr),
        .req_mem_d_or_tag (req_mem_d_or_tag),
        .req_mem_stall    (req_mem_stall),
        .rsp_mem_push     (rsp_mem_push),
        .rsp_mem_tag      (rsp_mem_tag),
        .rsp_mem_q        (rsp_mem_q),
        .rsp_mem_stall    (rsp_mem_stall),
        .rsp_push         (rsp_push),
        .rsp_q            (rsp_q),
        .outstanding_any  (outstanding_any),
        .err_sticky       (err_sticky)
    );

    always #5 clk = ~clk;

    // Reference model state and scoreboard
    iss_t        iss_q[$];
    rsp_t        rsp_exp_q[$];
    int          m_ptr;
    int          m_outst[N];
    logic        m_err;
    logic        m_any;
    logic [47:0] m_addr;
    logic [63:0] m_dt;
    logic [63:0] m_q;

    // What the DUT showed in the most recent cycle
    int          last_gidx;
    logic        last_strobe;
    logic        last_st;

    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic model_reset();
        m_ptr  = 0;
        for (int i = 0; i < N; i++) m_outst[i] = 0;
        m_err  = 1'b0;
        m_any  = 1'b0;
        m_addr = '0;
        m_dt   = '0;
        m_q    = '0;
        iss_q.delete();
        rsp_exp_q.delete();
    endtask

    // One clock cycle: compare at the falling edge, advance model, return
    // 1 ns after the rising edge so the caller can drive new inputs.
    task automatic cycle();
        iss_t         ei;
        rsp_t         er;
        logic [N-1:0] exp_push;
        logic [N-1:0] exp_grant;
        logic [N-1:0] elig;
        int           win;
        int           idx;
        int           t;
        logic         rsp_ok;

        @(negedge clk);

        // Registered memory request
        if (iss_q.size() > 0) begin
            ei = iss_q.pop_front();
        end else begin
            ei.ld = 1'b0; ei.st = 1'b0; ei.addr = m_addr; ei.dt = m_dt;
        end
        m_addr = ei.addr;
        m_dt   = ei.dt;
        n_cmp++;
        if ({req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag} !== {ei.ld, ei.st, ei.addr, ei.dt}) begin
            n_bad++;
            $display("FAIL mem_issue @%0t: got ld=%b st=%b addr=%h dt=%h expected ld=%b st=%b addr=%h dt=%h",
                     $time, req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag, ei.ld, ei.st, ei.addr, ei.dt);
        end
        last_strobe = req_mem_ld | req_mem_st;
        last_st     = req_mem_st;

        // Registered response
        exp_push = '0;
        if (rsp_exp_q.size() > 0) begin
            er = rsp_exp_q.pop_front();
            exp_push[er.tag] = 1'b1;
            m_q = er.q;
        end
        n_cmp++;
        if ({rsp_push, rsp_q} !== {exp_push, m_q}) begin
            n_bad++;
            $display("FAIL rsp_route @%0t: got push=%b q=%h expected push=%b q=%h",
                     $time, rsp_push, rsp_q, exp_push, m_q);
        end

        n_cmp++;
        if ({err_sticky, outstanding_any, rsp_mem_stall} !== {m_err, m_any, 1'b0}) begin
            n_bad++;
            $display("FAIL status @%0t: got err=%b any=%b rstall=%b expected err=%b any=%b rstall=0",
                     $time, err_sticky, outstanding_any, rsp_mem_stall, m_err, m_any);
        end

        // Predict this cycle's grant from the currently driven inputs
        elig = '0;
        for (int i = 0; i < N; i++) begin
            if (req_ld[i] && req_st[i]) m_err = 1'b1;
            elig[i] = !req_mem_stall && !(req_ld[i] && req_st[i]) &&
                      (req_st[i] || (req_ld[i] && (m_outst[i] < MAXO)));
        end
        win = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (win < 0 && elig[idx]) win = idx;
        end
        exp_grant = '0;
        if (win >= 0) exp_grant[win] = 1'b1;

        last_gidx = -1;
        for (int i = 0; i < N; i++) if (req_grant[i]) last_gidx = i;
        n_cmp++;
        if (req_grant !== exp_grant) begin
            n_bad++;
            $display("FAIL grant @%0t: got %b expected %b", $time, req_grant, exp_grant);
        end

        // Response validity uses the counters before this edge's update
        rsp_ok = 1'b0;
        t = int'(rsp_mem_tag);
        if (rsp_mem_push) begin
            if (t >= N) m_err = 1'b1;
            else if (m_outst[t] == 0) m_err = 1'b1;
            else rsp_ok = 1'b1;
        end

        if (win >= 0) begin
            ei.ld   = req_ld[win];
            ei.st   = req_st[win];
            ei.addr = req_addr[win*48 +: 48];
            ei.dt   = req_ld[win] ? {61'b0, 3'(win)} : req_d[win*64 +: 64];
            iss_q.push_back(ei);
            m_ptr = (win + 1) % N;
            if (req_ld[win]) m_outst[win]++;
        end
        if (rsp_ok) begin
            m_outst[t]--;
            er.tag = rsp_mem_tag;
            er.q   = rsp_mem_q;
            rsp_exp_q.push_back(er);
        end
        m_any = 1'b0;
        for (int i = 0; i < N; i++) if (m_outst[i] != 0) m_any = 1'b1;

        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        req_ld        = '0;
        req_st        = '0;
        req_mem_stall = 1'b0;
        rsp_mem_push  = 1'b0;
        rsp_mem_tag   = '0;
        rsp_mem_q     = '0;
        #12;
        n_cmp++;
        if ({req_grant, req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag,
             rsp_push, rsp_q, rsp_mem_stall, outstanding_any, err_sticky} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got grant=%b ld=%b st=%b addr=%h dt=%h push=%b q=%h err=%b any=%b expected all zero",
                     req_grant, req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag,
                     rsp_push, rsp_q, err_sticky, outstanding_any);
        end
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < N; i++) begin
            while (m_outst[i] > 0) begin
                rsp_mem_push = 1'b1;
                rsp_mem_tag  = 3'(i);
                rsp_mem_q    = {$urandom, $urandom};
                cycle();
            end
        end
        rsp_mem_push = 1'b0;
        cycle();
        cycle();
        n_cmp++;
        if (outstanding_any !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_idle: got outstanding_any=%b expected 0", outstanding_any);
        end
    endtask

    task automatic test_reset();
        req_addr = '0;
        req_d    = '0;
        do_reset();
        cycle();
    endtask

    task automatic test_single_load();
        req_ld[0] = 1'b1;
        req_addr[47:0] = 48'h100;
        cycle();
        n_cmp++;
        if (last_gidx !== 0) begin
            n_bad++;
            $display("FAIL single_grant: got %0d expected 0", last_gidx);
        end
        req_ld[0] = 1'b0;
        cycle();
        n_cmp++;
        if (last_strobe !== 1'b1) begin
            n_bad++;
            $display("FAIL single_strobe: got %b expected 1", last_strobe);
        end
        rsp_mem_push = 1'b1;
        rsp_mem_tag  = 3'd0;
        rsp_mem_q    = 64'hAB;
        cycle();
        rsp_mem_push = 1'b0;
        cycle();
        cycle();
        n_cmp++;
        if ({rsp_q, outstanding_any, err_sticky} !== {64'hAB, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL single_rsp_hold: got q=%h any=%b err=%b expected q=ab any=0 err=0",
                     rsp_q, outstanding_any, err_sticky);
        end
    endtask

    task automatic test_round_robin();
        int gs[8];
        int cnt[N];
        int g0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*48 +: 48] = 48'h1000 * (i + 1);
            cnt[i] = 0;
        end
        g0 = m_ptr;
        req_ld = '1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            gs[k] = last_gidx;
        end
        req_ld = '0;
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (gs[k] !== (g0 + k) % N) begin
                n_bad++;
                $display("FAIL rr_order[%0d]: got %0d expected %0d", k, gs[k], (g0 + k) % N);
            end
            if (gs[k] >= 0) cnt[gs[k]]++;
        end
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (cnt[i] !== 2) begin
                n_bad++;
                $display("FAIL rr_share[%0d]: got %0d expected 2", i, cnt[i]);
            end
        end
        drain();
    endtask

    task automatic test_credit_limit();
        int ng;
        ng = 0;
        req_ld[2] = 1'b1;
        req_addr[2*48 +: 48] = 48'hC0DE00;
        for (int k = 0; k < 17; k++) begin
            cycle();
            if (last_gidx == 2) ng++;
        end
        n_cmp++;
        if (ng !== 16 || last_gidx !== -1) begin
            n_bad++;
            $display("FAIL credit_cap: got %0d grants last=%0d expected 16 grants last=-1", ng, last_gidx);
        end
        rsp_mem_push = 1'b1;
        rsp_mem_tag  = 3'd2;
        rsp_mem_q    = 64'h2222;
        cycle();
        rsp_mem_push = 1'b0;
        n_cmp++;
        if (last_gidx !== -1) begin
            n_bad++;
            $display("FAIL credit_rsp_cycle: got %0d expected -1", last_gidx);
        end
        cycle();
        n_cmp++;
        if (last_gidx !== 2) begin
            n_bad++;
            $display("FAIL credit_regrant: got %0d expected 2", last_gidx);
        end
        req_ld[2] = 1'b0;
        drain();
    endtask

    task automatic test_stall();
        int gp;
        int ng;
        int ns;
        ng = 0;
        ns = 0;
        req_ld = '1;
        cycle();
        gp = last_gidx;
        req_mem_stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (last_gidx >= 0) ng++;
            if (k == 0) begin
                n_cmp++;
                if (last_strobe !== 1'b1) begin
                    n_bad++;
                    $display("FAIL stall_no_retract: got %b expected 1", last_strobe);
                end
            end else if (last_strobe) begin
                ns++;
            end
        end
        n_cmp++;
        if (ng !== 0 || ns !== 0) begin
            n_bad++;
            $display("FAIL stall_quiet: got %0d grants %0d strobes expected 0 and 0", ng, ns);
        end
        req_mem_stall = 1'b0;
        cycle();
        n_cmp++;
        if (last_gidx !== (gp + 1) % N) begin
            n_bad++;
            $display("FAIL stall_resume: got %0d expected %0d", last_gidx, (gp + 1) % N);
        end
        req_ld = '0;
        drain();
    endtask

    task automatic test_store_and_simultaneous();
        req_st[3] = 1'b1;
        req_addr[3*48 +: 48] = 48'h2000;
        req_d[3*64 +: 64] = 64'h3FF0000000000000;
        cycle();
        n_cmp++;
        if (last_gidx !== 3) begin
            n_bad++;
            $display("FAIL store_grant: got %0d expected 3", last_gidx);
        end
        req_st[3] = 1'b0;
        cycle();
        cycle();
        n_cmp++;
        if (outstanding_any !== 1'b0 || req_mem_d_or_tag !== 64'h3FF0000000000000) begin
            n_bad++;
            $display("FAIL store_no_credit: got any=%b dt=%h expected any=0 dt=3ff0000000000000",
                     outstanding_any, req_mem_d_or_tag);
        end
        req_ld[1] = 1'b1;
        req_addr[1*48 +: 48] = 48'h5000;
        cycle();
        rsp_mem_push = 1'b1;
        rsp_mem_tag  = 3'd1;
        rsp_mem_q    = 64'h1111;
        cycle();
        n_cmp++;
        if (last_gidx !== 1) begin
            n_bad++;
            $display("FAIL simul_grant: got %0d expected 1", last_gidx);
        end
        req_ld[1]    = 1'b0;
        rsp_mem_push = 1'b0;
        cycle();
        cycle();
        n_cmp++;
        if (outstanding_any !== 1'b1) begin
            n_bad++;
            $display("FAIL simul_credit_kept: got %b expected 1", outstanding_any);
        end
        rsp_mem_push = 1'b1;
        rsp_mem_q    = 64'h1212;
        cycle();
        rsp_mem_push = 1'b0;
        cycle();
        cycle();
        n_cmp++;
        if ({outstanding_any, err_sticky} !== 2'b00) begin
            n_bad++;
            $display("FAIL simul_drained: got any=%b err=%b expected 0 0", outstanding_any, err_sticky);
        end
    endtask

    task automatic test_errors();
        rsp_mem_push = 1'b1;
        rsp_mem_tag  = 3'd5;
        rsp_mem_q    = 64'h5555;
        cycle();
        rsp_mem_push = 1'b0;
        cycle();
        cycle();
        cycle();
        n_cmp++;
        if (err_sticky !== 1'b1) begin
            n_bad++;
            $display("FAIL err_bad_tag: got %b expected 1", err_sticky);
        end
        do_reset();
        cycle();
        rsp_mem_push = 1'b1;
        rsp_mem_tag  = 3'd0;
        rsp_mem_q    = 64'h0F0F;
        cycle();
        rsp_mem_push = 1'b0;
        cycle();
        n_cmp++;
        if (err_sticky !== 1'b1) begin
            n_bad++;
            $display("FAIL err_no_credit: got %b expected 1", err_sticky);
        end
        do_reset();
        req_ld[0] = 1'b1;
        req_st[0] = 1'b1;
        cycle();
        n_cmp++;
        if (last_gidx !== -1) begin
            n_bad++;
            $display("FAIL err_ldst_grant: got %0d expected -1", last_gidx);
        end
        req_ld[0] = 1'b0;
        req_st[0] = 1'b0;
        cycle();
        n_cmp++;
        if (err_sticky !== 1'b1) begin
            n_bad++;
            $display("FAIL err_ldst_flag: got %b expected 1", err_sticky);
        end
        do_reset();
        cycle();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_round_robin();
        test_credit_limit();
        test_stall();
        test_store_and_simultaneous();
        test_errors();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
